sobel_window_ctrl: RTL and testbench
====================================

SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 Parameter MAX_WIDTH, default 1024; maximum active pixels per line, sizes both line buffers.
REQ-002 Parameter VS_POL, default 1; active level of in_VSync.
REQ-003 clk  in  1  single clock; pixel stream is sampled every rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 en  in  1  filter enable request, sampled only at frame start.
REQ-006 in_Pixel  in  24  RGB pixel; the window uses the full 24 bits.
REQ-007 in_HSync, in_VSync, in_VDE  in  1 each  video timing; in_VDE qualifies in_Pixel.
REQ-008 out_M0, out_M1, out_M2  out  72 each  window rows top/middle/bottom; bits [23:0] column x-2, [47:24] x-1, [71:48] x.
REQ-009 out_Pixel  out  24  in_Pixel delayed 2 clk (pass-through path).
REQ-010 out_HSync, out_VSync, out_VDE  out  1 each  inputs delayed 2 clk.
REQ-011 out_en  out  1  drives the filter datapath enable: frame enable AND window valid.
REQ-012 status  out  1  frame-latched enable (en_frame).
REQ-013 ovf  out  1  sticky line-overflow flag.

Function
REQ-014 Latency: every output is exactly 2 clk after the input cycle it represents; the output image is spatially offset by (+1,+1).
REQ-015 Frame start = in_VSync transition to VS_POL level; at that edge en_frame <= en, row <= 0, ovf <= 0.
REQ-016 col increments on each cycle with in_VDE=1; col <= 0 on the cycle after in_VDE falls.
REQ-017 row increments, saturating at 2, on each in_VDE falling edge.
REQ-018 FSM IDLE -> FILL on frame start; FILL -> RUN on the in_VDE falling edge that makes row=2; RUN -> FILL on frame start; any state -> IDLE on reset.
REQ-019 Two line buffers LB0 (line y-2) and LB1 (line y-1), depth MAX_WIDTH x 24, 1-clk read, read-before-write at address col.
REQ-020 On in_VDE=1: LB1 read -> LB0 written, in_Pixel -> LB1 written, both at address col, in the same cycle.
REQ-021 Window shift, one clk after read: each row register shifts left 24 bits, new column = {LB0 data, LB1 data, registered pixel} into out_M0/M1/M2 [71:48].
REQ-022 Window valid = state RUN AND registered VDE AND registered col >= 2 AND NOT line overflow.
REQ-023 out_en = en_frame AND window valid, aligned with out_M*; out_M* hold their value when window valid is 0.
REQ-024 Overflow: in_VDE=1 with col = MAX_WIDTH -> no RAM write, col holds, ovf set, window valid forced 0 until line end.
REQ-025 en changes mid-frame have no effect until the next frame start.
REQ-026 Simultaneous in_VDE falling edge and frame start: frame start wins; row <= 0.
REQ-027 Line buffer contents are never reset; the FILL state guarantees stale data is never marked valid.

Reset
REQ-028 rst_n=0 at a clk edge: state IDLE, col=0, row=0, en_frame=0, ovf=0, all delay stages and out_M* = 0, all outputs 0.
REQ-029 Reset mid-frame discards the frame; out_en stays 0 until two full lines after the next frame start.

Structure
REQ-030 Package sobel_pkg holds PIX_W=24, WIN_W=72, CTRL_LAT=2, and the FSM state encoding (IDLE, FILL, RUN).
REQ-031 One sub-module, sobel_line_buf: single-clock read-first RAM, inferred as block RAM; instantiated twice.

Verification
REQ-032 Frame of 8x4, en=1, pixel = {8'h0, row, col}: first out_en=1 is 2 clk after input (2,2); out_M0[23:0]=0x000000, out_M2[71:48]=0x000202.
REQ-033 en toggled 1->0 mid-frame: out_en and status stay 1 for the rest of that frame; both 0 after the next frame start.
REQ-034 Line of MAX_WIDTH+3 active pixels: ovf=1 from the first excess pixel; out_en=0 for the excess; ovf clears at the next frame start.
REQ-035 Random sync/VDE/pixel pattern: out_HSync/VSync/VDE/Pixel equal the inputs delayed by exactly 2 clk in every cycle.
REQ-036 rst_n=0 for 1 clk during row 3: all outputs 0 on the next cycle; no out_en until row 2 of the following frame.
REQ-037 in_VDE falls in the same cycle as the VSync edge: row=0 and state FILL afterwards.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, latency and FSM encoding for the Sobel 3x3 window controller.
package sobel_pkg;

   localparam int PIX_W    = 24;  // one RGB pixel
   localparam int WIN_W    = 72;  // three pixels per window row
   localparam int CTRL_LAT = 2;   // input-to-output latency in clk cycles

   typedef enum logic [1:0] {
      IDLE = 2'd0,  // no frame seen since reset
      FILL = 2'd1,  // first two lines of a frame are loading the line buffers
      RUN  = 2'd2   // both line buffers hold lines of the current frame
   } state_t;

   // One cycle of video timing plus pixel, as carried by the pass-through path.
   typedef struct packed {
      logic [PIX_W-1:0] pix;
      logic             hs;
      logic             vs;
      logic             vde;
   } video_t;

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Video stream in, 3x3 window plus delayed stream out, and frame enable/status.
interface sobel_window_ctrl_if;
   import sobel_pkg::*;

   logic             en;
   logic [PIX_W-1:0] in_Pixel;
   logic             in_HSync;
   logic             in_VSync;
   logic             in_VDE;

   logic [WIN_W-1:0] out_M0;
   logic [WIN_W-1:0] out_M1;
   logic [WIN_W-1:0] out_M2;
   logic [PIX_W-1:0] out_Pixel;
   logic             out_HSync;
   logic             out_VSync;
   logic             out_VDE;
   logic             out_en;
   logic             status;
   logic             ovf;

   // Video source / result sink side.
   modport master (
      output en, in_Pixel, in_HSync, in_VSync, in_VDE,
      input  out_M0, out_M1, out_M2, out_Pixel, out_HSync, out_VSync, out_VDE,
      input  out_en, status, ovf
   );

   // Window controller side.
   modport slave (
      input  en, in_Pixel, in_HSync, in_VSync, in_VDE,
      output out_M0, out_M1, out_M2, out_Pixel, out_HSync, out_VSync, out_VDE,
      output out_en, status, ovf
   );

endinterface

// File: rtl/sobel_line_buf.sv
// One video line of pixels: single-clock RAM, registered read, read-first.
module sobel_line_buf
   import sobel_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [PIX_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [PIX_W-1:0] rdata
);

   logic [PIX_W-1:0] mem [DEPTH];

   // Registered read returns the old word when the same address is written this cycle.
   // NOTE: the array has no reset branch on purpose; a reset would stop block-RAM inference,
   // and stale words are never flagged valid because the FSM refills both lines per frame.
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_window_ctrl.sv
// 3x3 window generator for a Sobel filter: two line buffers, window shift registers,
// frame/line tracking FSM and a matched 2-clk pass-through of the video timing.
module sobel_window_ctrl
   import sobel_pkg::*;
#(
   parameter int MAX_WIDTH = 1024,
   parameter bit VS_POL    = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   sobel_window_ctrl_if.slave vid
);

   localparam int                AW      = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam int                CW      = $clog2(MAX_WIDTH + 1);
   localparam logic [CW-1:0]     COL_MAX = CW'(MAX_WIDTH);

   video_t           dly [CTRL_LAT];
   state_t           state;
   logic [CW-1:0]    col;
   logic [1:0]       row;
   logic             en_frame;
   logic             ovf_q;

   logic [CW-1:0]    col_d1;
   logic             run_d1;
   logic             en_d1;
   logic             lovf_d1;
   logic             wr_d1;
   logic [AW-1:0]    addr_d1;

   logic [PIX_W-1:0] lb0_q;
   logic [PIX_W-1:0] lb1_q;
   logic [WIN_W-1:0] m0, m1, m2;
   logic             out_en_q;

   logic             frame_start;
   logic             vde_fall;
   logic             col_ovf;
   logic             lb_we;
   logic [AW-1:0]    lb_addr;
   logic             win_valid;

   // Edge detection against the first delay stage, overflow and line-buffer addressing.
   // NOTE: every output gets a default at the top of the block so no path can infer a latch.
   always_comb begin
      frame_start = 1'b0;
      vde_fall    = 1'b0;
      col_ovf     = 1'b0;
      lb_we       = 1'b0;
      lb_addr     = '0;
      win_valid   = 1'b0;

      frame_start = (vid.in_VSync == VS_POL) && (dly[0].vs != VS_POL);
      vde_fall    = !vid.in_VDE && dly[0].vde;
      col_ovf     = (col == COL_MAX);
      lb_we       = vid.in_VDE && !col_ovf;
      lb_addr     = col_ovf ? '0 : AW'(col);
      win_valid   = run_d1 && dly[0].vde && (col_d1 >= CW'(2)) && !lovf_d1;
   end

   // Pass-through delay line for pixel and timing; stage 0 also serves as the edge reference.
   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CTRL_LAT; i++) begin
            dly[i] <= '0;
         end
      end else begin
         dly[0] <= {vid.in_Pixel, vid.in_HSync, vid.in_VSync, vid.in_VDE};
         for (int i = 1; i < CTRL_LAT; i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

   // Frame/line tracking FSM: column counter, saturating row count, frame enable, overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         col      <= '0;
         row      <= '0;
         en_frame <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (vid.in_VDE) begin
            if (!col_ovf) begin
               col <= col + CW'(1);
            end else begin
               ovf_q <= 1'b1;
            end
         end else begin
            col <= '0;
         end

         // A frame start outranks a coincident line end.
         if (frame_start) begin
            state    <= FILL;
            row      <= '0;
            en_frame <= vid.en;
            ovf_q    <= 1'b0;
         end else if (vde_fall) begin
            if (row != 2'd2) begin
               row <= row + 2'd1;
            end
            if (state == FILL && row == 2'd1) begin
               state <= RUN;
            end
         end
      end
   end

   // Stage 1: carry per-pixel qualifiers alongside the line-buffer read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_d1  <= '0;
         run_d1  <= 1'b0;
         en_d1   <= 1'b0;
         lovf_d1 <= 1'b0;
         wr_d1   <= 1'b0;
         addr_d1 <= '0;
      end else begin
         col_d1  <= col;
         run_d1  <= (state == RUN);
         en_d1   <= en_frame;
         lovf_d1 <= vid.in_VDE && col_ovf;
         wr_d1   <= lb_we;
         addr_d1 <= lb_addr;
      end
   end

   // Stage 2: shift the newest column into the window and register the datapath enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m0       <= '0;
         m1       <= '0;
         m2       <= '0;
         out_en_q <= 1'b0;
      end else begin
         out_en_q <= en_d1 && win_valid;
         if (dly[0].vde && !lovf_d1) begin
            m0 <= {lb0_q,      m0[WIN_W-1:PIX_W]};
            m1 <= {lb1_q,      m1[WIN_W-1:PIX_W]};
            m2 <= {dly[0].pix, m2[WIN_W-1:PIX_W]};
         end
      end
   end

   // LB0 (line y-2) takes what LB1 held at the same column, one cycle after LB1 is read.
   sobel_line_buf #(.DEPTH(MAX_WIDTH), .AW(AW)) u_lb0 (
      .clk   (clk),
      .we    (wr_d1),
      .waddr (addr_d1),
      .wdata (lb1_q),
      .raddr (lb_addr),
      .rdata (lb0_q)
   );

   // LB1 (line y-1) is read and overwritten with the incoming pixel in the same cycle.
   sobel_line_buf #(.DEPTH(MAX_WIDTH), .AW(AW)) u_lb1 (
      .clk   (clk),
      .we    (lb_we),
      .waddr (lb_addr),
      .wdata (vid.in_Pixel),
      .raddr (lb_addr),
      .rdata (lb1_q)
   );

   assign vid.out_Pixel = dly[CTRL_LAT-1].pix;
   assign vid.out_HSync = dly[CTRL_LAT-1].hs;
   assign vid.out_VSync = dly[CTRL_LAT-1].vs;
   assign vid.out_VDE   = dly[CTRL_LAT-1].vde;
   assign vid.out_M0    = m0;
   assign vid.out_M1    = m1;
   assign vid.out_M2    = m2;
   assign vid.out_en    = out_en_q;
   assign vid.status    = en_frame;
   assign vid.ovf       = ovf_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl: every driven cycle pushes its expected output,
// which is popped and compared two clocks later.
module tb_sobel_window_ctrl;

   localparam int MAXW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sobel_window_ctrl_if vid ();

   sobel_window_ctrl #(.MAX_WIDTH(MAXW), .VS_POL(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vid   (vid)
   );

   typedef struct {
      logic [23:0] pix;
      logic        hs;
      logic        vs;
      logic        vde;
      logic        en_o;
      bit          chk_m;
      logic [71:0] m0;
      logic [71:0] m1;
      logic [71:0] m2;
   } rec_t;

   rec_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Frame-level model state
   bit armed      = 1'b0;  // a frame start has been seen since the last reset
   bit en_frame_m = 1'b0;
   bit ovf_m      = 1'b0;
   bit chk_sts    = 1'b1;
   bit en_drv     = 1'b0;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] pix_of(input int y, input int x, input logic [7:0] seed);
      return {seed, 8'(y), 8'(x)};
   endfunction

   task automatic drive(input logic vs, input logic hs, input logic vde, input logic [23:0] pix,
                        input logic exp_en, input bit chk_m,
                        input logic [71:0] e0, input logic [71:0] e1, input logic [71:0] e2);
      rec_t r;
      rec_t o;
      vid.in_VSync = vs;
      vid.in_HSync = hs;
      vid.in_VDE   = vde;
      vid.in_Pixel = pix;
      vid.en       = en_drv;
      r.pix = pix; r.hs = hs; r.vs = vs; r.vde = vde; r.en_o = exp_en;
      r.chk_m = chk_m; r.m0 = e0; r.m1 = e1; r.m2 = e2;
      sb.push_back(r);
      @(posedge clk);
      #1;
      if (sb.size() >= 2) begin
         o = sb.pop_front();
         check("out_Pixel", 72'(vid.out_Pixel), 72'(o.pix));
         check("out_HSync", 72'(vid.out_HSync), 72'(o.hs));
         check("out_VSync", 72'(vid.out_VSync), 72'(o.vs));
         check("out_VDE",   72'(vid.out_VDE),   72'(o.vde));
         check("out_en",    72'(vid.out_en),    72'(o.en_o));
         if (o.chk_m) begin
            check("out_M0", vid.out_M0, o.m0);
            check("out_M1", vid.out_M1, o.m1);
            check("out_M2", vid.out_M2, o.m2);
         end
      end
      if (chk_sts) begin
         check("status", 72'(vid.status), 72'(en_frame_m));
         check("ovf",    72'(vid.ovf),    72'(ovf_m));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // One-cycle synchronous reset; everything observable must be zero right after it.
   task automatic do_reset();
      rec_t z;
      sb.delete();
      z.pix = '0; z.hs = 1'b0; z.vs = 1'b0; z.vde = 1'b0; z.en_o = 1'b0;
      z.chk_m = 1'b1; z.m0 = '0; z.m1 = '0; z.m2 = '0;
      sb.push_back(z);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_out_Pixel", 72'(vid.out_Pixel), 72'(0));
      check("rst_out_HSync", 72'(vid.out_HSync), 72'(0));
      check("rst_out_VSync", 72'(vid.out_VSync), 72'(0));
      check("rst_out_VDE",   72'(vid.out_VDE),   72'(0));
      check("rst_out_en",    72'(vid.out_en),    72'(0));
      check("rst_out_M0",    vid.out_M0,         72'(0));
      check("rst_out_M1",    vid.out_M1,         72'(0));
      check("rst_out_M2",    vid.out_M2,         72'(0));
      check("rst_status",    72'(vid.status),    72'(0));
      check("rst_ovf",       72'(vid.ovf),       72'(0));
      rst_n      = 1'b1;
      armed      = 1'b0;
      en_frame_m = 1'b0;
      ovf_m      = 1'b0;
   endtask

   // h lines of w pixels; en switches to en_mid at the start of line 2; optional 1-clk reset
   // at pixel 3 of line rst_row; the last line is followed by tail_last blank cycles.
   task automatic frame(input int h, input int w, input bit en_start, input bit en_mid,
                        input int rst_row, input int tail_last, input logic [7:0] seed);
      logic [71:0] e0, e1, e2;
      bit          v;
      int          tail;
      en_drv     = en_start;
      armed      = 1'b1;
      en_frame_m = en_start;
      ovf_m      = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, '0, '0, '0);
      for (int y = 0; y < h; y++) begin
         if (y == 2) en_drv = en_mid;
         for (int x = 0; x < w; x++) begin
            if (y == rst_row && x == 3) do_reset();
            if (x >= MAXW) ovf_m = 1'b1;
            v  = armed && (y >= 2) && (x >= 2) && (x < MAXW);
            e0 = {pix_of(y-2, x, seed), pix_of(y-2, x-1, seed), pix_of(y-2, x-2, seed)};
            e1 = {pix_of(y-1, x, seed), pix_of(y-1, x-1, seed), pix_of(y-1, x-2, seed)};
            e2 = {pix_of(y,   x, seed), pix_of(y,   x-1, seed), pix_of(y,   x-2, seed)};
            drive(1'b0, 1'b0, 1'b1, pix_of(y, x, seed), v && en_frame_m, v, e0, e1, e2);
         end
         tail = (y == h - 1) ? tail_last : 3;
         for (int b = 0; b < tail; b++) begin
            drive(1'b0, (b == 1), 1'b0, 24'h0, 1'b0, 1'b0, '0, '0, '0);
         end
      end
   endtask

   initial begin
      vid.en       = 1'b0;
      vid.in_Pixel = '0;
      vid.in_HSync = 1'b0;
      vid.in_VSync = 1'b0;
      vid.in_VDE   = 1'b0;

      do_reset();
      idle(3);

      // 8x4 frame, pixel = {0,row,col}; first valid window at (2,2)
      frame(4, 8, 1'b1, 1'b1, -1, 3, 8'h00);
      // en drops mid-frame: no effect until the next frame start
      frame(4, 8, 1'b1, 1'b0, -1, 3, 8'h11);
      frame(4, 8, 1'b0, 1'b0, -1, 3, 8'h22);
      // every line overflows by three pixels
      frame(4, MAXW + 3, 1'b1, 1'b1, -1, 3, 8'h33);
      // ovf clears at this frame start
      frame(4, 8, 1'b1, 1'b1, -1, 3, 8'h44);
      // reset during line 3, then a clean frame that must refill two lines
      frame(5, 8, 1'b1, 1'b1, 3, 3, 8'h55);
      frame(4, 8, 1'b1, 1'b1, -1, 3, 8'h66);
      // line end and next frame start in the same cycle
      frame(1, 8, 1'b1, 1'b1, -1, 0, 8'h77);
      frame(4, 8, 1'b1, 1'b1, -1, 3, 8'h88);
      idle(2);

      // random timing and pixels with the filter disabled: pure 2-clk pass-through
      do_reset();
      chk_sts = 1'b0;
      en_drv  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               24'($urandom), 1'b0, 1'b0, '0, '0, '0);
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
